// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, ALUOp encodings, FSM states.
package alu_pkg;

   // 4-bit ALU control codes produced by the ALU control decoder
   localparam logic [3:0] AND_OP = 4'd0;
   localparam logic [3:0] OR_OP  = 4'd1;
   localparam logic [3:0] ADD_OP = 4'd2;
   localparam logic [3:0] SLL_OP = 4'd3;
   localparam logic [3:0] SRL_OP = 4'd4;
   localparam logic [3:0] SUB_OP = 4'd5;
   localparam logic [3:0] SLT_OP = 4'd7;
   localparam logic [3:0] NOR_OP = 4'd12;

   // ALUOp from the main control unit to the ALU control decoder
   typedef enum logic [1:0] {
      AluOpAdd   = 2'd0,
      AluOpSub   = 2'd1,
      AluOpFunct = 2'd2
   } alu_op_e;

   // Execution unit sequencing
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } exec_state_e;

   function automatic logic is_shift(input logic [3:0] code);
      return (code == SLL_OP) || (code == SRL_OP);
   endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Combinational single-cycle ALU datapath (no shifts).
module alu_logic_core
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [3:0]        alu_control,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] result
);

   // Select the operation; shift and undefined codes yield zero
   always_comb begin
      result = '0;
      case (alu_control)
         AND_OP:  result = op_a & op_b;
         OR_OP:   result = op_a | op_b;
         ADD_OP:  result = op_a + op_b;
         SUB_OP:  result = op_a - op_b;
         SLT_OP:  result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         NOR_OP:  result = ~(op_a | op_b);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus iterative one-bit-per-cycle SLL/SRL.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_control,
   input  logic [DATA_W-1:0]  op_a,
   input  logic [DATA_W-1:0]  op_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result,
   output logic               zero
);

   exec_state_e        state_q, state_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic [DATA_W-1:0]  shreg_q, shreg_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               zero_q, zero_d;
   logic               res_we;
   logic [DATA_W-1:0]  core_res;
   logic [DATA_W-1:0]  sh_src, sh_one;
   logic               sh_left;

   alu_logic_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .result      (core_res)
   );

   // One-bit shift step; the accept edge performs the first step directly on op_b
   always_comb begin
      sh_src  = (state_q == StIdle) ? op_b : shreg_q;
      sh_left = (state_q == StIdle) ? (alu_control == SLL_OP) : left_q;
      sh_one  = sh_left ? (sh_src << 1) : (sh_src >> 1);
   end

   // Next-state, shifter and result capture
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      res_we   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (is_shift(alu_control)) begin
                  left_d = (alu_control == SLL_OP);
                  if (shamt == '0) begin
                     result_d = op_b;
                     res_we   = 1'b1;
                     state_d  = StDone;
                  end else if (shamt == SHAMT_W'(1)) begin
                     result_d = sh_one;
                     res_we   = 1'b1;
                     state_d  = StDone;
                  end else begin
                     // cnt holds the shifts still to do after this edge
                     shreg_d = sh_one;
                     cnt_d   = shamt - 1'b1;
                     state_d = StShift;
                  end
               end else begin
                  result_d = core_res;
                  res_we   = 1'b1;
                  state_d  = StDone;
               end
            end
         end
         StShift: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
               result_d = sh_one;
               res_we   = 1'b1;
               state_d  = StDone;
            end else begin
               shreg_d = sh_one;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      zero_d = res_we ? (result_d == '0) : zero_q;
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= StIdle;
         result_q <= '0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + small random scoreboard bench for alu_exec_unit.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        arst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] op_a, op_b;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   typedef struct {
      logic [31:0] res;
      logic        zf;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(
      .DATA_W  (32),
      .SHAMT_W (5)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .shamt       (shamt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero)
   );

   // Reference behaviour written from the operation definitions
   function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] s);
      case (c)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd3:    return b << s;
         4'd4:    return b >> s;
         4'd5:    return a - b;
         4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12:   return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   // Drive one op, then wait for and check its result; hold>0 applies backpressure
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input int hold);
      exp_t e;
      exp_t got;
      int   lat;
      logic [31:0] r_hold;
      @(negedge clk);
      e.res = model(c, a, b, s);
      e.zf  = (e.res == 32'd0);
      e.lat = ((c == 4'd3 || c == 4'd4) && s != 5'd0) ? int'(s) : 1;
      exp_q.push_back(e);
      check("in_ready_before", {31'd0, in_ready}, 32'd1);
      in_valid    = 1'b1;
      alu_control = c;
      op_a        = a;
      op_b        = b;
      shamt       = s;
      out_ready   = (hold == 0);
      @(posedge clk);
      #1;
      // Scramble inputs: the unit must use the values captured at accept
      in_valid    = 1'b0;
      op_a        = $urandom;
      op_b        = $urandom;
      shamt       = 5'($urandom);
      alu_control = 4'($urandom);
      lat = 1;
      if (e.lat > 1) check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      got = exp_q.pop_front();
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("latency", lat, got.lat);
      check("result", result, got.res);
      check("zero", {31'd0, zero}, {31'd0, got.zf});
      if (hold > 0) begin
         r_hold = result;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, got.res);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         end
         check("bp_stable", result, r_hold);
         @(negedge clk);
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("idle_valid", {31'd0, out_valid}, 32'd0);
      check("idle_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      arst        = 1'b1;
      in_valid    = 1'b0;
      alu_control = 4'd0;
      op_a        = '0;
      op_b        = '0;
      shamt       = '0;
      out_ready   = 1'b1;
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd0);
      @(negedge clk);
      arst = 1'b0;

      run_op(4'd2, 32'd5, 32'd7, 5'd0, 0);                  // ADD -> 12
      run_op(4'd5, 32'd3, 32'd3, 5'd0, 0);                  // SUB -> 0, zero
      run_op(4'd5, 32'd0, 32'd1, 5'd0, 0);                  // SUB wrap
      run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);          // SLT -1<1
      run_op(4'd7, 32'd1, 32'hFFFF_FFFF, 5'd0, 0);          // SLT 1<-1
      run_op(4'd3, 32'd0, 32'd1, 5'd4, 0);                  // SLL 4 -> 16
      run_op(4'd4, 32'd0, 32'h8000_0000, 5'd31, 0);         // SRL 31 -> 1
      run_op(4'd3, 32'd0, 32'h1234_5678, 5'd0, 0);          // shamt 0
      run_op(4'd4, 32'd0, 32'hF000_000F, 5'd1, 0);          // SRL 1
      run_op(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 0);  // AND
      run_op(4'd1, 32'hF000_0000, 32'h0000_000F, 5'd0, 0);  // OR
      run_op(4'd12, 32'hF000_0000, 32'h0000_000F, 5'd0, 0); // NOR
      run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 5'd0, 5);          // ADD with backpressure
      run_op(4'd6, 32'd9, 32'd9, 5'd0, 0);                  // undefined -> 0

      // Reset in the middle of a 10-step SLL
      @(negedge clk);
      in_valid    = 1'b1;
      alu_control = 4'd3;
      op_b        = 32'd1;
      shamt       = 5'd10;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      arst = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_zero", {31'd0, zero}, 32'd0);
      @(negedge clk);
      arst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("no_stale_result", {31'd0, out_valid}, 32'd0);
      run_op(4'd2, 32'd100, 32'd23, 5'd0, 0);

      for (int i = 0; i < 10; i++) begin
         run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
